// File: rtl/led_pkg.sv
// Shared constants for the LED PWM fader: polarity encodings and duty ceiling helper.
package led_pkg;

    localparam int unsigned LED_ACTIVE_HIGH = 1;
    localparam int unsigned LED_ACTIVE_LOW  = 0;

    function automatic int unsigned duty_max(input int unsigned pwm_bits);
        return (32'd1 << pwm_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Pattern/fade control in, LED pin drive and busy status out.
interface led_pwm_fader_if #(
    parameter int unsigned LED_NUM = 6
);

    logic [LED_NUM-1:0] pattern_in;
    logic               fade_en;
    logic [LED_NUM-1:0] led;
    logic               busy;

    modport master (
        output pattern_in,
        output fade_en,
        input  led,
        input  busy
    );

    modport slave (
        input  pattern_in,
        input  fade_en,
        output led,
        output busy
    );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating duty ramp toward its on/off target, PWM compare and
// registered polarity-corrected pin drive.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned LED_MODE = LED_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                step_tick_i,
    input  logic                tgt_i,
    input  logic                fade_en_i,
    output logic                led_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(duty_max(PWM_BITS));
    localparam logic LedOff = (LED_MODE == LED_ACTIVE_HIGH) ? 1'b0 : 1'b1;

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] tgt_duty;
    logic                on;
    logic                led_q, led_d;

    assign tgt_duty = tgt_i ? DutyMax : '0;

    always_comb begin
        duty_d = duty_q;
        if (!fade_en_i) begin
            duty_d = tgt_duty;
        end else if (step_tick_i) begin
            if (tgt_i && (duty_q != DutyMax)) begin
                duty_d = duty_q + PWM_BITS'(1);
            end else if (!tgt_i && (duty_q != '0)) begin
                duty_d = duty_q - PWM_BITS'(1);
            end
        end
    end

    // pwm_cnt never reaches DutyMax, so full duty stays lit for the whole period.
    assign on    = (duty_q > pwm_cnt_i);
    assign led_d = on ^ LedOff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            led_q  <= LedOff;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = (duty_q != tgt_duty);

endmodule

// File: rtl/led_pwm_fader.sv
// Per-channel PWM cross-fader for the water-LED pattern: shared PWM/step timebase,
// pattern capture and busy summary around one led_pwm_channel per LED.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned LED_NUM  = 6,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 100_000,
    parameter int unsigned LED_MODE = LED_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst,
    led_pwm_fader_if.slave   bus
);

    localparam logic [PWM_BITS-1:0] DutyMax = PWM_BITS'(duty_max(PWM_BITS));
    localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic [LED_NUM-1:0]  pat_q;
    logic                step_tick;
    logic [LED_NUM-1:0]  ch_led;
    logic [LED_NUM-1:0]  ch_busy;

    assign step_tick = (step_cnt_q == StepLast);

    always_comb begin
        pwm_cnt_d  = (pwm_cnt_q >= DutyMax - PWM_BITS'(1)) ? '0 : pwm_cnt_q + PWM_BITS'(1);
        step_cnt_d = step_tick ? '0 : step_cnt_q + StepW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            pat_q      <= '0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            pat_q      <= bus.pattern_in;
        end
    end

    for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS),
            .LED_MODE (LED_MODE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pwm_cnt_i   (pwm_cnt_q),
            .step_tick_i (step_tick),
            .tgt_i       (pat_q[i]),
            .fade_en_i   (bus.fade_en),
            .led_o       (ch_led[i]),
            .busy_o      (ch_busy[i])
        );
    end

    assign bus.led  = ch_led;
    assign bus.busy = |ch_busy;

endmodule
